// File: rtl/tanh_act_sequencer.sv
// Front end for the bfloat16 tanh CORDIC engine: buffers operands in a small FIFO,
// resolves special/saturating operands locally and sequences one engine operation at a time.
module tanh_act_sequencer #(
  parameter int          DEPTH     = 4,
  parameter int          TAG_W     = 4,
  parameter logic [7:0]  SAT_EXP   = 8'h81,
  parameter logic [7:0]  SMALL_EXP = 8'h77,
  parameter logic [7:0]  TIMEOUT   = 8'd63
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_z,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic             eng_en,
  output logic [15:0]      eng_z,
  input  logic             eng_done,
  input  logic [15:0]      eng_out
);

  localparam int         AW   = $clog2(DEPTH);
  localparam logic [15:0] QNAN = 16'h7FC0;

  typedef enum logic [1:0] {IDLE, LAUNCH, ARM, WAIT} state_t;

  state_t state, state_nx;

  logic [TAG_W+15:0] mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
  logic              push, pop, empty;
  logic [15:0]       head_z;
  logic [TAG_W-1:0]  head_tag;
  logic [7:0]        head_exp;
  logic [6:0]        head_man;
  logic              bypass;
  logic [15:0]       bypass_y;
  logic [TAG_W-1:0]  eng_tag;
  logic [7:0]        cnt;
  logic              seen_low;
  logic              timed_out, eng_load;

  assign push      = in_valid && in_ready;
  assign empty     = (wr_ptr == rd_ptr);
  assign pop       = (state == IDLE) && !empty && (!out_valid || out_ready);
  assign wr_ptr_nx = wr_ptr + {{AW{1'b0}}, push};
  assign rd_ptr_nx = rd_ptr + {{AW{1'b0}}, pop};

  // in_ready is registered from the post-update pointers so it never lags a fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      in_ready <= 1'b1;
    end else begin
      wr_ptr   <= wr_ptr_nx;
      rd_ptr   <= rd_ptr_nx;
      in_ready <= !((wr_ptr_nx[AW] != rd_ptr_nx[AW]) &&
                    (wr_ptr_nx[AW-1:0] == rd_ptr_nx[AW-1:0]));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {in_tag, in_z};
  end

  assign {head_tag, head_z} = mem[rd_ptr[AW-1:0]];
  assign head_exp = head_z[14:7];
  assign head_man = head_z[6:0];

  always_comb begin
    bypass   = 1'b1;
    bypass_y = head_z;
    if (head_exp == 8'hFF && head_man != 7'd0) bypass_y = QNAN;
    else if (head_exp >= SAT_EXP)              bypass_y = {head_z[15], 15'h3F80};
    else if (head_exp == 8'h00)                bypass_y = {head_z[15], 15'h0000};
    else if (head_exp < SMALL_EXP)             bypass_y = head_z;
    else                                       bypass   = 1'b0;
  end

  // ARM waits for done to drop so a stale done from the prior operation is never taken.
  always_comb begin
    state_nx  = state;
    eng_en    = 1'b0;
    timed_out = 1'b0;
    eng_load  = 1'b0;
    case (state)
      IDLE:   if (pop && !bypass) state_nx = LAUNCH;
      LAUNCH: begin
        eng_en   = 1'b1;
        state_nx = ARM;
      end
      ARM: begin
        if (cnt == TIMEOUT) begin
          timed_out = 1'b1;
          state_nx  = IDLE;
        end else if (!eng_done) begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (seen_low && eng_done) begin
          eng_load = 1'b1;
          state_nx = IDLE;
        end else if (cnt == TIMEOUT) begin
          timed_out = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      eng_z    <= '0;
      eng_tag  <= '0;
      cnt      <= '0;
      seen_low <= 1'b0;
    end else begin
      state <= state_nx;
      if (pop && !bypass) begin
        eng_z   <= head_z;
        eng_tag <= head_tag;
      end
      case (state)
        LAUNCH: begin
          cnt      <= '0;
          seen_low <= 1'b0;
        end
        ARM: begin
          cnt <= cnt + 8'd1;
          if (!eng_done) seen_low <= 1'b1;
        end
        WAIT:    cnt <= cnt + 8'd1;
        default: ;
      endcase
    end
  end

  // Only one source can load per cycle: bypass loads happen in IDLE, engine loads outside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_y     <= '0;
      out_tag   <= '0;
      out_err   <= 1'b0;
    end else if (pop && bypass) begin
      out_valid <= 1'b1;
      out_y     <= bypass_y;
      out_tag   <= head_tag;
      out_err   <= 1'b0;
    end else if (eng_load) begin
      out_valid <= 1'b1;
      out_y     <= eng_out;
      out_tag   <= eng_tag;
      out_err   <= 1'b0;
    end else if (timed_out) begin
      out_valid <= 1'b1;
      out_y     <= QNAN;
      out_tag   <= eng_tag;
      out_err   <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tanh_act_sequencer.sv
// Randomized self-checking bench for tanh_act_sequencer with a behavioural engine
// model and an in-order expected-result queue.
module tb_tanh_act_sequencer;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      in_z = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [15:0]      out_y;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;
  logic             eng_en;
  logic [15:0]      eng_z;
  logic             eng_done = 1'b1;
  logic [15:0]      eng_out = '0;

  typedef struct {
    logic [15:0]      y;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] eng_q[$];
  int          hs_q[$];

  int checks = 0, errors = 0;
  int cyc = 0, n_in = 0, n_out = 0, n_eng_exp = 0, n_eng_en = 0;
  int en_cyc = 0, rise_cyc = 0;
  logic prev_en = 1'b0, prev_valid = 1'b0;
  logic [15:0]      last_y = '0;
  logic [TAG_W-1:0] last_tag = '0;
  logic             last_err = 1'b0;
  bit   stuck = 1'b0, lat_rand = 1'b0;
  int   eng_lat = 40, ready_mode = 0;
  bit   eng_busy = 1'b0;
  int   eng_cnt = 0;
  logic [15:0] eng_op = '0;
  logic [16:0] r_mon;
  exp_t        e_mon;

  tanh_act_sequencer #(.DEPTH(4), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_z(in_z), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_tag(out_tag), .out_err(out_err),
    .eng_en(eng_en), .eng_z(eng_z), .eng_done(eng_done), .eng_out(eng_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // tanh by the classification rules; the fake engine returns z - 0x13 (0.5 -> 0x3EED).
  function automatic logic [16:0] ref_result(input logic [15:0] z, input bit stuck_now);
    int e, m;
    e = int'(z[14:7]);
    m = int'(z[6:0]);
    if (e == 255 && m != 0) return {1'b0, 16'h7FC0};
    if (e >= 129)           return {1'b0, z[15], 15'h3F80};
    if (e == 0)             return {1'b0, z[15], 15'h0000};
    if (e < 119)            return {1'b0, z};
    if (stuck_now)          return {1'b1, 16'h7FC0};
    return {1'b0, z - 16'h0013};
  endfunction

  function automatic bit uses_engine(input logic [15:0] z);
    int e;
    e = int'(z[14:7]);
    return (e >= 119) && (e < 129);
  endfunction

  function automatic logic [15:0] rand_operand();
    logic [7:0] e;
    logic [6:0] m;
    m = 7'($urandom);
    case ($urandom_range(0, 5))
      0: begin
        e = 8'hFF;
        if ($urandom_range(0, 1) == 0) m = 7'd0;
      end
      1:       e = 8'($urandom_range(8'hFE, 8'h81));
      2:       e = 8'h00;
      3:       e = 8'($urandom_range(8'h76, 1));
      default: e = 8'($urandom_range(8'h80, 8'h77));
    endcase
    return {1'($urandom), e, m};
  endfunction

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Engine model: drops done on launch, raises it with the result after its latency.
  always @(negedge clk) begin
    if (rst) begin
      eng_busy = 1'b0;
      eng_done = 1'b0;
    end else if (eng_en) begin
      eng_op = eng_z;
      if (stuck) begin
        eng_done = 1'b1;
        eng_busy = 1'b0;
      end else begin
        eng_done = 1'b0;
        eng_busy = 1'b1;
        eng_cnt  = lat_rand ? int'($urandom_range(12, 2)) : eng_lat;
      end
    end else if (eng_busy) begin
      eng_cnt--;
      if (eng_cnt <= 0) begin
        checkOutput("eng_z_hold", eng_z, eng_op);
        eng_out  = eng_op - 16'h0013;
        eng_done = 1'b1;
        eng_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      eng_q.delete();
      n_in = 0; n_out = 0; n_eng_exp = 0; n_eng_en = 0;
      prev_en = 1'b0; prev_valid = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        r_mon   = ref_result(in_z, stuck);
        e_mon.y = r_mon[15:0];
        e_mon.tag = in_tag;
        e_mon.err = r_mon[16];
        exp_q.push_back(e_mon);
        n_in++;
        if (uses_engine(in_z)) begin
          eng_q.push_back(in_z);
          n_eng_exp++;
        end
      end
      if (out_valid) begin
        if (!prev_valid) rise_cyc = cyc;
        if (exp_q.size() == 0) begin
          checkOutput("out_valid_unexpected", out_valid, 0);
        end else begin
          checkOutput("out_y", out_y, exp_q[0].y);
          checkOutput("out_tag", out_tag, exp_q[0].tag);
          checkOutput("out_err", out_err, exp_q[0].err);
          if (out_ready) begin
            last_y = out_y; last_tag = out_tag; last_err = out_err;
            void'(exp_q.pop_front());
            n_out++;
            hs_q.push_back(cyc);
          end
        end
      end
      prev_valid = out_valid;
      if (eng_en) begin
        checkOutput("eng_en_pulse", prev_en, 0);
        n_eng_en++;
        en_cyc = cyc;
        if (eng_q.size() == 0) checkOutput("eng_en_unexpected", eng_en, 0);
        else                   checkOutput("eng_z", eng_z, eng_q.pop_front());
      end
      prev_en = eng_en;
    end
  end

  task automatic applyStimulus(input logic [15:0] z, input logic [TAG_W-1:0] tag);
    int   guard = 0;
    logic acc;
    in_valid = 1'b1;
    in_z     = z;
    in_tag   = tag;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 500);
    if (!acc) checkOutput("push_timeout", in_ready, 1);
    in_valid = 1'b0;
  endtask

  task automatic waitDrain(input int limit);
    int k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (exp_q.size() != 0) checkOutput("drain_timeout", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int base, hs_base, lat;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_y", out_y, 0);
    checkOutput("rst_out_tag", out_tag, 0);
    checkOutput("rst_out_err", out_err, 0);
    checkOutput("rst_eng_en", eng_en, 0);
    checkOutput("rst_eng_z", eng_z, 0);
    rst = 1'b0;
    ready_mode = 1;
    repeat (2) @(posedge clk);
    #1;

    // 0.5 through the engine with a 40-cycle latency
    base = n_eng_en;
    applyStimulus(16'h3F00, 4'hA);
    waitDrain(200);
    checkOutput("t1_eng_en_count", n_eng_en - base, 1);
    checkOutput("t1_y", last_y, 16'h3EED);
    checkOutput("t1_tag", last_tag, 4'hA);
    checkOutput("t1_err", last_err, 0);

    // saturating operands stream back-to-back
    base = n_eng_en;
    hs_q.delete();
    applyStimulus(16'h4100, 4'h1);
    applyStimulus(16'hC100, 4'h2);
    applyStimulus(16'h7F80, 4'h3);
    waitDrain(50);
    checkOutput("t2_eng_en_count", n_eng_en - base, 0);
    checkOutput("t2_results", hs_q.size(), 3);
    if (hs_q.size() == 3) begin
      checkOutput("t2_gap0", hs_q[1] - hs_q[0], 1);
      checkOutput("t2_gap1", hs_q[2] - hs_q[1], 1);
    end
    checkOutput("t2_last_y", last_y, 16'h3F80);

    // NaN, negative zero, tiny value
    base = n_eng_en;
    applyStimulus(16'h7FC1, 4'h4);
    applyStimulus(16'h8000, 4'h5);
    applyStimulus(16'h3B00, 4'h6);
    waitDrain(50);
    checkOutput("t3_eng_en_count", n_eng_en - base, 0);
    checkOutput("t3_last_y", last_y, 16'h3B00);

    // done never drops: timeout path
    stuck = 1'b1;
    applyStimulus(16'h3F00, 4'h5);
    waitDrain(300);
    checkOutput("t4_y", last_y, 16'h7FC0);
    checkOutput("t4_err", last_err, 1);
    lat = rise_cyc - en_cyc;
    checkOutput("t4_timeout_window", (lat >= 60 && lat <= 70), 1);
    stuck = 1'b0;

    // fill: one result parked in the output register, four in the FIFO
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    hs_base = hs_q.size();
    applyStimulus(16'h4100, 4'h0);
    for (int i = 0; i < 4; i++) applyStimulus(16'h3B00 + 16'(i), 4'(8 + i));
    checkOutput("t5_full", in_ready, 0);
    in_valid = 1'b1;
    in_z     = 16'h3C00;
    in_tag   = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("t5_still_full", in_ready, 0);
    ready_mode = 1;
    waitDrain(100);
    checkOutput("t5_drained", hs_q.size() - hs_base, 5);
    ready_mode = 2;
    lat_rand   = 1'b1;
    for (int i = 0; i < 8; i++) applyStimulus(rand_operand(), 4'(i));
    waitDrain(500);

    // reset while the engine is busy and the FIFO is full
    ready_mode = 1;
    lat_rand   = 1'b0;
    eng_lat    = 40;
    applyStimulus(16'h3F00, 4'h1);
    for (int i = 0; i < 4; i++) applyStimulus(16'h4100, 4'(i));
    checkOutput("t6_full", in_ready, 0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_out_valid", out_valid, 0);
    checkOutput("t6_rst_in_ready", in_ready, 1);
    checkOutput("t6_rst_eng_en", eng_en, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    eng_lat = 5;
    @(posedge clk);
    #1;
    applyStimulus(16'h3F00, 4'h7);
    waitDrain(100);
    checkOutput("t6_fresh_eng_en", n_eng_en, 1);
    checkOutput("t6_y", last_y, 16'h3EED);
    checkOutput("t6_tag", last_tag, 4'h7);

    // randomized mix with random backpressure and engine latency
    ready_mode = 2;
    lat_rand   = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(3, 1)) @(posedge clk);
      #0;
      applyStimulus(rand_operand(), 4'($urandom));
    end
    waitDrain(3000);

    checkOutput("final_queue_empty", exp_q.size(), 0);
    checkOutput("final_out_count", n_out, n_in);
    checkOutput("final_eng_count", n_eng_en, n_eng_exp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
